// File: rtl/imem_loader.sv
// Instruction store for the CPU fetch path: streams a program in over a
// valid/ready port while holding the PC at zero, then serves reads combinationally.
module imem_loader #(
    parameter int ADDR_W = 4,
    parameter int INS_W  = 11,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] PC_CURR,
    output logic [INS_W-1:0]  INS,
    output logic              set_pc,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [INS_W-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [INS_W-1:0]    mem [DEPTH];

    // NOTE: the array is cleared by async reset and on every load start, so
    // unloaded words always read 0; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            set_pc     <= 1'b1;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE, RUN: begin
                    // A data word arriving with load_start is dropped on purpose.
                    if (load_start) begin
                        state      <= LOAD;
                        wr_addr    <= '0;
                        set_pc     <= 1'b1;
                        load_ready <= 1'b1;
                        for (int i = 0; i < DEPTH; i++) begin
                            mem[i] <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (load_valid && load_ready) begin
                        mem[wr_addr] <= load_data;
                        wr_addr      <= wr_addr + 1'b1;
                        // The 16th word ends the load even without load_last.
                        if (load_last || wr_addr == ADDR_W'(DEPTH - 1)) begin
                            state      <= RUN;
                            set_pc     <= 1'b0;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    set_pc     <= 1'b1;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency read so next-PC logic sees the word in the same cycle; gated
    // to 0 outside RUN so no jump opcode is ever decoded while loading.
    always_comb begin
        INS = '0;
        if (state == RUN) begin
            INS = mem[PC_CURR];
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load sequences by hand, read-back checks
// driven from a table of {PC, expected instruction} records.
module tb_imem_loader;

    localparam int ADDR_W = 4;
    localparam int INS_W  = 11;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] pc_curr;
    logic [INS_W-1:0]  ins;
    logic              set_pc;
    logic              load_start;
    logic              load_valid;
    logic [INS_W-1:0]  load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;

    imem_loader #(.ADDR_W(ADDR_W), .INS_W(INS_W), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .PC_CURR    (pc_curr),
        .INS        (ins),
        .set_pc     (set_pc),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_done  (load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int               phase;
        logic [ADDR_W-1:0] pc;
        logic [INS_W-1:0]  exp_ins;
    } read_vec_t;

    read_vec_t rv [16];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reads(input int phase);
        for (int i = 0; i < 16; i++) begin
            if (rv[i].phase == phase) begin
                pc_curr = rv[i].pc;
                #1;
                check($sformatf("read p%0d pc%0d", phase, rv[i].pc), 32'(ins), 32'(rv[i].exp_ins));
            end
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("load entered ready", 32'(load_ready), 32'd1);
        check("load set_pc", 32'(set_pc), 32'd1);
    endtask

    // Presents one word; checks LOAD-state outputs before the accepting edge.
    task automatic send(input logic [INS_W-1:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        #1;
        check("send ready", 32'(load_ready), 32'd1);
        check("send ins gated", 32'(ins), 32'd0);
        check("send set_pc", 32'(set_pc), 32'd1);
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic expect_run_entry();
        check("done pulse", 32'(load_done), 32'd1);
        check("run set_pc", 32'(set_pc), 32'd0);
        check("run ready", 32'(load_ready), 32'd0);
        step();
        check("done cleared", 32'(load_done), 32'd0);
    endtask

    initial begin
        rv[0]  = '{0, 4'd0,  11'h123};
        rv[1]  = '{0, 4'd1,  11'h456};
        rv[2]  = '{0, 4'd2,  11'h7FF};
        rv[3]  = '{0, 4'd3,  11'h000};
        rv[4]  = '{1, 4'd0,  11'h400};
        rv[5]  = '{1, 4'd1,  11'h000};
        rv[6]  = '{1, 4'd2,  11'h000};
        rv[7]  = '{1, 4'd3,  11'h000};
        rv[8]  = '{2, 4'd15, 11'h10F};
        rv[9]  = '{2, 4'd0,  11'h100};
        rv[10] = '{2, 4'd8,  11'h108};
        rv[11] = '{3, 4'd0,  11'h0AA};
        rv[12] = '{3, 4'd1,  11'h055};
        rv[13] = '{3, 4'd2,  11'h000};
        rv[14] = '{4, 4'd0,  11'h3C3};
        rv[15] = '{4, 4'd1,  11'h000};

        rst_n = 1'b0; pc_curr = '0; load_start = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("reset set_pc", 32'(set_pc), 32'd1);
        check("reset done", 32'(load_done), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            pc_curr = ADDR_W'(i);
            #1;
            check("idle set_pc", 32'(set_pc), 32'd1);
            check("idle ins", 32'(ins), 32'd0);
            check("idle ready", 32'(load_ready), 32'd0);
        end

        // Short program
        start_load();
        send(11'h123, 1'b0);
        check("no early done", 32'(load_done), 32'd0);
        send(11'h456, 1'b0);
        send(11'h7FF, 1'b1);
        expect_run_entry();
        apply_reads(0);

        // Reload from RUN with a stray data word alongside load_start
        load_start = 1'b1; load_valid = 1'b1; load_data = 11'h6AA;
        step();
        load_start = 1'b0; load_valid = 1'b0;
        check("reload set_pc", 32'(set_pc), 32'd1);
        check("reload ins gated", 32'(ins), 32'd0);
        check("reload ready", 32'(load_ready), 32'd1);
        send(11'h400, 1'b1);
        expect_run_entry();
        apply_reads(1);

        // Full 16-word load, load_last never set; load_start mid-load ignored
        start_load();
        for (int k = 0; k < 16; k++) begin
            if (k == 8) load_start = 1'b1;
            send(11'h100 + 11'(k), 1'b0);
            load_start = 1'b0;
            if (k < 15) check("full still loading", 32'(load_done), 32'd0);
        end
        expect_run_entry();
        apply_reads(2);

        // Backpressure gaps: valid 1,0,0,1
        start_load();
        send(11'h0AA, 1'b0);
        for (int g = 0; g < 2; g++) begin
            check("gap ready", 32'(load_ready), 32'd1);
            check("gap no done", 32'(load_done), 32'd0);
            step();
        end
        send(11'h055, 1'b1);
        expect_run_entry();
        check("single done", 32'(load_done), 32'd0);
        apply_reads(3);

        // Reset mid-load after 2 of 5 words
        start_load();
        send(11'h111, 1'b0);
        send(11'h222, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midreset set_pc", 32'(set_pc), 32'd1);
        check("midreset ready", 32'(load_ready), 32'd0);
        check("midreset ins", 32'(ins), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("post reset idle", 32'(load_ready), 32'd0);
        start_load();
        send(11'h3C3, 1'b1);
        expect_run_entry();
        apply_reads(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
